// File: rtl/gray_fifo_ptr_ctrl.sv
// gray_fifo_ptr_ctrl
//   Single-clock pointer controller for a 2**ADDR_WIDTH-entry FIFO RAM. Grants
//   push/pop requests against registered full/empty flags, advances binary read
//   and write pointers, and publishes each pointer as registered Gray code (one
//   bit change per step) for a downstream CDC synchronizer. RAM is external.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous reset, active-high
//   push_i         write request
//   pop_i          read request
//   clr_err_i      clears sticky overflow/underflow flags
//   push_ok_o      push accepted this cycle (combinational)
//   pop_ok_o       pop accepted this cycle (combinational)
//   wr_addr_o      RAM write address (low bits of binary write pointer)
//   rd_addr_o      RAM read address (low bits of binary read pointer)
//   wr_ptr_gray_o  Gray-coded write pointer, ADDR_WIDTH+1 bits
//   rd_ptr_gray_o  Gray-coded read pointer, ADDR_WIDTH+1 bits
//   level_o        occupancy 0..DEPTH
//   full_o         level_o == DEPTH
//   empty_o        level_o == 0
//   overflow_o     sticky: push requested while full
//   underflow_o    sticky: pop requested while empty

module gray_fifo_ptr_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic                  clr_err_i,
  output logic                  push_ok_o,
  output logic                  pop_ok_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray_o,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic [PW-1:0] level_next;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Grants depend only on registered flags, so push and pop never gate each other.
  assign push_ok_o = push_i & ~full_o;
  assign pop_ok_o  = pop_i & ~empty_o;

  assign wr_ptr_next = wr_ptr + PW'(push_ok_o);
  assign rd_ptr_next = rd_ptr + PW'(pop_ok_o);

  always_comb begin
    level_next = level_o;
    case ({push_ok_o, pop_ok_o})
      2'b10:   level_next = level_o + PW'(1);
      2'b01:   level_next = level_o - PW'(1);
      default: level_next = level_o;
    endcase
  end

  assign wr_addr_o = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr_o = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wr_ptr_gray_o <= '0;
      rd_ptr_gray_o <= '0;
      level_o       <= '0;
      full_o        <= 1'b0;
      empty_o       <= 1'b1;
    end else begin
      wr_ptr        <= wr_ptr_next;
      rd_ptr        <= rd_ptr_next;
      // Gray loads from the next binary value so both views move on the same edge.
      wr_ptr_gray_o <= bin2gray(wr_ptr_next);
      rd_ptr_gray_o <= bin2gray(rd_ptr_next);
      level_o       <= level_next;
      full_o        <= (level_next == DEPTH);
      empty_o       <= (level_next == '0);
    end
  end

  // A new rejection takes priority over a clear in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_i && full_o)
        overflow_o <= 1'b1;
      else if (clr_err_i)
        overflow_o <= 1'b0;

      if (pop_i && empty_o)
        underflow_o <= 1'b1;
      else if (clr_err_i)
        underflow_o <= 1'b0;
    end
  end

endmodule
